piso_frame_tx: RTL and testbench
================================

# piso_frame_tx

Parallel-in, serial-out frame transmitter: accepts a WIDTH-bit word over a valid/ready handshake and emits it on a single-bit line as a framed serial stream (start bit, data MSB-first, optional parity, stop bit). It is the transmit end for the shift-register serial chains in this codebase. Its `sout` drives the `sin` of a downstream serial-in shift chain, and MSB-first order means a 4-stage chain reproduces the bit order unchanged, 4 cycles later. One bit is emitted per `clk` cycle.

## Interface
- `WIDTH`, default 8: data word width; legal range ≥ 2.

- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous reset, active-low; sampled on the rising edge of `clk`.
- `din`  input  WIDTH  parallel word; sampled only on a handshake edge.
- `din_valid`  input  1  source has a word on `din`.
- `din_ready`  output  1  block can accept a word this cycle.
- `sout`  output  1  serial line; idles high.
- `busy`  output  1  a frame is on the line (START through STOP).
- `frame_done`  output  1  high during the stop-bit cycle of each frame.

## Operation
- States:
  - IDLE
  - START
  - DATA
  - PARITY (only with macro)
  - STOP
- State, shift register, bit counter (`$clog2(WIDTH)` bits) and `sout` are registered. `din_ready`, `busy` and `frame_done` decode from state only; they have no combinational path from inputs.
- Handshake: a word is accepted on an edge where `din_valid && din_ready` is true. `din` is copied to the shift register on that edge. The source holds `din` stable while `din_valid` is high and `din_ready` is low. `din` is ignored at all other times.
- `din_ready` is 1 in IDLE and STOP, and 0 in START, DATA and PARITY.
- IDLE: `sout`=1, `busy`=0. Handshake → START.
- START: `sout`=0 for one cycle → DATA, with the counter cleared.
- DATA: `sout` = shift register MSB, shifting left each cycle, for WIDTH cycles.
  - Counter = WIDTH−1 at the edge → PARITY if enabled, else STOP.
- PARITY: `sout` = XOR of the WIDTH data bits (even parity) for one cycle → STOP.
- STOP: `sout`=1, `frame_done`=1, `busy`=1 for one cycle.
  - Handshake on the STOP-exit edge → START directly. There is no idle gap.
  - Otherwise → IDLE.
- Frame length F = WIDTH+2 cycles, or WIDTH+3 with parity. Sustained throughput is one word per F cycles.

## Timing
- Reset: every edge with `reset`=0 forces IDLE, so after that edge `sout`=1, `busy`=0, `frame_done`=0 and `din_ready`=1. The shift register and counter clear to 0.
- Reset overrides any handshake on the same edge; the word is dropped.
- Reset mid-frame aborts the frame at that edge. The line returns high immediately and the partial frame is never resumed or retransmitted.
- Latency: handshake at edge E → start bit on `sout` in cycle E..E+1 → data bit `din[WIDTH-1]` in cycle E+1..E+2 → stop bit ends F cycles after E.
- `din_valid` high in START/DATA/PARITY has no effect. Nothing is queued.
- Before reset is first applied, outputs are undefined; the bench applies reset for ≥ 1 edge before checking.

## Configuration
- Macro: `PISO_TX_PARITY_EN`.
  - Defined: PARITY state present; one even-parity bit is inserted between the last data bit and the stop bit; F = WIDTH+3.
  - Undefined: PARITY state and parity logic are not compiled; DATA goes straight to STOP; F = WIDTH+2.

## Test plan
- Reset values: hold `reset`=0 for 2 edges with `din_valid`=1 and `din`=8'hFF → `sout`=1, `busy`=0, `din_ready`=1, `frame_done`=0, and no frame follows while reset stays low.
- Single frame, no parity, WIDTH=8, `din`=8'hA5 accepted at edge E → `sout` over the next 10 cycles is 0,1,0,1,0,0,1,0,1,1.
  - `frame_done`=1 only in the 10th cycle.
  - Returns to IDLE.
- Parity build:
  - 8'hA5 → cycles 0..8 as above, then parity 0, then stop 1 (11 cycles).
  - 8'h07 → parity 1.
- Back-to-back: `din_valid` held high with 8'hFF then 8'h00 → the second start bit immediately follows the first stop bit; `busy` stays 1 across both frames; exactly 2 `frame_done` pulses.
- Reset mid-frame: assert `reset`=0 for one edge during data bit 3 of 8'hC3 → `sout`=1 from that edge onward, `busy`=0. A new word 8'h3C afterwards transmits cleanly with correct bit order.
- Loopback: `sout` → `sin` of a 4-stage serial-in shift chain with a shared `clk`/`reset` → the chain output reproduces the `sout` sequence exactly 4 cycles later for 8'hA5.

Source files
------------

// File: rtl/piso_frame_tx.sv
// Purpose  : framed parallel-in/serial-out transmitter (start, data MSB-first, [parity], stop).
// Latency  : start bit appears the cycle after the accept edge; frame lasts WIDTH+2 cycles (WIDTH+3 with parity).
// Backpr.  : din_ready high only in IDLE and STOP; nothing is queued while a frame is on the line.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous reset, active-low
//   din        parallel word, captured on the din_valid && din_ready edge
//   din_valid  source offers a word
//   din_ready  block can accept a word this cycle (IDLE or STOP)
//   sout       serial line, idles high
//   busy       a frame is on the line (START through STOP)
//   frame_done high during the stop-bit cycle
//
// Optional feature: define PISO_TX_PARITY_EN to insert one even-parity bit
// between the last data bit and the stop bit.
module piso_frame_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PISO_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
`ifdef PISO_TX_PARITY_EN
  logic             par;
`endif

  // Status outputs decode purely from the state register.
  assign din_ready  = (state == IDLE) || (state == STOP);
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP);

  // sout is loaded with the value belonging to the state being entered, so
  // the line bit and the state always line up in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      sout  <= 1'b1;
      shreg <= '0;
      cnt   <= '0;
`ifdef PISO_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          sout <= 1'b1;
          if (din_valid) begin
            shreg <= din;
            state <= START;
            sout  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par   <= ^din;
`endif
          end
        end

        START: begin
          state <= DATA;
          cnt   <= '0;
          sout  <= shreg[WIDTH-1];
          shreg <= {shreg[WIDTH-2:0], 1'b0};
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
`ifdef PISO_TX_PARITY_EN
            state <= PARITY;
            sout  <= par;
`else
            state <= STOP;
            sout  <= 1'b1;
`endif
          end else begin
            cnt   <= cnt + 1'b1;
            sout  <= shreg[WIDTH-1];
            shreg <= {shreg[WIDTH-2:0], 1'b0};
          end
        end

`ifdef PISO_TX_PARITY_EN
        PARITY: begin
          state <= STOP;
          sout  <= 1'b1;
        end
`endif

        STOP: begin
          // A word offered during the stop bit starts the next frame with no idle gap.
          if (din_valid) begin
            shreg <= din;
            state <= START;
            sout  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par   <= ^din;
`endif
          end else begin
            state <= IDLE;
            sout  <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          sout  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Purpose  : self-checking bench for piso_frame_tx with WIDTH=8.
// Latency  : frames checked cycle by cycle from the accept edge onward.
// Backpr.  : exercises stop-bit back-to-back acceptance and ignored din_valid mid-frame.
module tb_piso_frame_tx;

`ifdef PISO_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sout;
  logic       busy;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  piso_frame_tx #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sout      (sout),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 4-stage serial-in chain for the loopback check.
  logic [3:0] chain;
  always_ff @(posedge clk) begin
    if (!reset) chain <= '0;
    else        chain <= {chain[2:0], sout};
  end

  typedef struct {
    logic [7:0]  d;
    logic [10:0] exp;   // frame bits, first line bit at index F-1
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " idle sout"},  32'(sout), 32'd1);
    check({tag, " idle busy"},  32'(busy), 32'd0);
    check({tag, " idle ready"}, 32'(din_ready), 32'd1);
    check({tag, " idle done"},  32'(frame_done), 32'd0);
  endtask

  // Called at a sample point while IDLE; leaves the bench at a sample point in IDLE.
  task automatic run_frame(input logic [7:0] d, input logic [10:0] exp, input string tag);
    din       = d;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < F; i++) begin
      check($sformatf("%s c%0d sout", tag, i),  32'(sout), 32'(exp[F-1-i]));
      check($sformatf("%s c%0d busy", tag, i),  32'(busy), 32'd1);
      check($sformatf("%s c%0d done", tag, i),  32'(frame_done), 32'(i == F-1));
      check($sformatf("%s c%0d ready", tag, i), 32'(din_ready), 32'(i == F-1));
      tick();
    end
    check_idle(tag);
  endtask

  initial begin
    logic [10:0] e_ff, e_00, e_a5, e_3c;
    int          done_cnt;
    logic [21:0] b2b;

`ifdef PISO_TX_PARITY_EN
    tbl[0] = '{8'hA5, 11'b0_10100101_0_1};
    tbl[1] = '{8'h07, 11'b0_00000111_1_1};
    tbl[2] = '{8'hC3, 11'b0_11000011_0_1};
    tbl[3] = '{8'h01, 11'b0_00000001_1_1};
    e_ff   = 11'b0_11111111_0_1;
    e_00   = 11'b0_00000000_0_1;
    e_3c   = 11'b0_00111100_0_1;
`else
    tbl[0] = '{8'hA5, {1'b0, 10'b0_10100101_1}};
    tbl[1] = '{8'h07, {1'b0, 10'b0_00000111_1}};
    tbl[2] = '{8'hC3, {1'b0, 10'b0_11000011_1}};
    tbl[3] = '{8'h01, {1'b0, 10'b0_00000001_1}};
    e_ff   = {1'b0, 10'b0_11111111_1};
    e_00   = {1'b0, 10'b0_00000000_1};
    e_3c   = {1'b0, 10'b0_00111100_1};
`endif
    e_a5 = tbl[0].exp;

    // Reset with a word offered: must be dropped.
    reset     = 1'b0;
    din       = 8'hFF;
    din_valid = 1'b1;
    tick();
    tick();
    check_idle("reset");
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset hold%0d sout", i), 32'(sout), 32'd1);
      check($sformatf("reset hold%0d busy", i), 32'(busy), 32'd0);
    end
    din_valid = 1'b0;
    reset     = 1'b1;
    tick();
    check_idle("post-reset");

    // Table-driven single frames.
    foreach (tbl[k]) begin
      run_frame(tbl[k].d, tbl[k].exp, $sformatf("vec%0d", k));
      tick();
    end

    // Back-to-back: second word accepted on the stop-exit edge of the first.
    b2b       = {e_ff[F-1:0], e_00[F-1:0]} << (22 - 2*F);
    done_cnt  = 0;
    din       = 8'hFF;
    din_valid = 1'b1;
    tick();
    din = 8'h00;
    for (int i = 0; i < 2*F; i++) begin
      if (i == F) din_valid = 1'b0;
      check($sformatf("b2b c%0d sout", i), 32'(sout), 32'(b2b[21-i]));
      check($sformatf("b2b c%0d busy", i), 32'(busy), 32'd1);
      if (frame_done) done_cnt++;
      tick();
    end
    check("b2b done pulses", 32'(done_cnt), 32'd2);
    check_idle("b2b");

    // Mid-frame reset during the fourth data bit of C3.
    din       = 8'hC3;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_idle("midrst");
    for (int i = 0; i < F + 2; i++) begin
      tick();
      check($sformatf("midrst after%0d sout", i), 32'(sout), 32'd1);
      check($sformatf("midrst after%0d busy", i), 32'(busy), 32'd0);
    end
    run_frame(8'h3C, e_3c, "after-rst 3C");

    // din_valid during a frame is ignored: only one frame results.
    din       = 8'hA5;
    din_valid = 1'b1;
    tick();
    din = 8'h00;
    din_valid = 1'b1;
    for (int i = 0; i < F - 1; i++) tick();
    din_valid = 1'b0;
    check("ignore stop sout", 32'(sout), 32'd1);
    check("ignore stop done", 32'(frame_done), 32'd1);
    tick();
    check_idle("ignore");

    // Loopback through the 4-stage chain: chain output lags sout by 4 cycles.
    for (int i = 0; i < 5; i++) tick();
    din       = 8'hA5;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < F + 4; i++) begin
      if (i < 4) check($sformatf("loop c%0d", i), 32'(chain[3]), 32'd1);
      else       check($sformatf("loop c%0d", i), 32'(chain[3]), 32'(e_a5[F-1-(i-4)]));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
